// File: rtl/conta_pkg.sv
// Shared types and defaults for the programmable-modulo counter slice.
package conta_pkg;

    localparam int CONTA_WIDTH   = 18;
    localparam int CONTA_PRESC_W = 8;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } conta_state_e;

endpackage

// File: rtl/conta_presc.sv
// Prescaler for conta_prog_mod: counts 0..presc_div while enabled and
// emits one tick on each wrap. Only built with CONTA_PRESCALER_EN.
module conta_presc
    import conta_pkg::*;
#(
    parameter int PRESC_W = CONTA_PRESC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               count_en,
    input  logic               clear,
    input  logic [PRESC_W-1:0] presc_div,
    output logic               tick
);

    logic [PRESC_W-1:0] cnt_q;
    logic [PRESC_W-1:0] cnt_d;

    assign tick = count_en && (cnt_q == presc_div);

    // Next prescaler count: clear on launch, wrap on tick, else advance.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = {PRESC_W{1'b0}};
        end else if (tick) begin
            cnt_d = {PRESC_W{1'b0}};
        end else if (count_en) begin
            cnt_d = cnt_q + {{(PRESC_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Prescaler count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {PRESC_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/conta_prog_mod.sv
// Programmable-modulo up/down counter with load, clear, terminal-count pulse
// and IDLE/RUN/DONE run control. Define CONTA_PRESCALER_EN for the prescaler.
module conta_prog_mod
    import conta_pkg::*;
#(
    parameter int WIDTH = CONTA_WIDTH
`ifdef CONTA_PRESCALER_EN
    ,
    parameter int PRESC_W = CONTA_PRESC_W
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               start,
    input  logic               stop,
    input  logic               clr,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    input  logic               up_dn,
    input  logic               one_shot,
    input  logic [WIDTH-1:0]   modulo,
`ifdef CONTA_PRESCALER_EN
    input  logic [PRESC_W-1:0] presc_div,
`endif
    output logic [WIDTH-1:0]   cuenta,
    output logic               tc,
    output logic               busy,
    output logic               done
);

    conta_state_e     state_q, state_d;
    logic [WIDTH-1:0] cuenta_q, cuenta_d;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             start_acc_s;
    logic             step_s;
    logic             step_en_s;
    logic [WIDTH-1:0] step_val_s;
    logic             step_tc_s;

    assign start_acc_s = start && !stop && (state_q != ST_RUN);

`ifdef CONTA_PRESCALER_EN
    logic presc_tick_s;

    conta_presc #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk       (clk),
        .rst       (rst),
        .count_en  (en && (state_q == ST_RUN)),
        .clear     (start_acc_s),
        .presc_div (presc_div),
        .tick      (presc_tick_s)
    );

    assign step_en_s = en && presc_tick_s;
`else
    assign step_en_s = en;
`endif

    assign step_s = (state_q == ST_RUN) && step_en_s;

    // Value and terminal flag a step would produce; an out-of-range count
    // going up is treated as a wrap, and M=0 makes every step terminal.
    always_comb begin
        step_val_s = cuenta_q;
        step_tc_s  = 1'b0;
        if (modulo == {WIDTH{1'b0}}) begin
            step_val_s = {WIDTH{1'b0}};
            step_tc_s  = 1'b1;
        end else if (up_dn == DIR_UP) begin
            if (cuenta_q >= modulo) begin
                step_val_s = {WIDTH{1'b0}};
                step_tc_s  = 1'b0;
            end else begin
                step_val_s = cuenta_q + {{(WIDTH-1){1'b0}}, 1'b1};
                step_tc_s  = (step_val_s == modulo);
            end
        end else begin
            if (cuenta_q == {WIDTH{1'b0}}) begin
                step_val_s = modulo;
                step_tc_s  = 1'b0;
            end else begin
                step_val_s = cuenta_q - {{(WIDTH-1){1'b0}}, 1'b1};
                step_tc_s  = (step_val_s == {WIDTH{1'b0}});
            end
        end
    end

    // Next count, terminal pulse and run-control state.
    always_comb begin
        cuenta_d = cuenta_q;
        tc_d     = 1'b0;
        if (clr) begin
            cuenta_d = {WIDTH{1'b0}};
        end else if (load) begin
            cuenta_d = (load_val > modulo) ? modulo : load_val;
        end else if (start_acc_s) begin
            cuenta_d = (up_dn == DIR_UP) ? {WIDTH{1'b0}} : modulo;
        end else if (step_s) begin
            cuenta_d = step_val_s;
            tc_d     = step_tc_s;
        end else begin
            cuenta_d = cuenta_q;
        end

        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = start_acc_s ? ST_RUN : ST_IDLE;
            ST_RUN:  state_d = (tc_d && one_shot) ? ST_DONE : ST_RUN;
            ST_DONE: state_d = start_acc_s ? ST_RUN : ST_DONE;
            default: state_d = ST_IDLE;
        endcase
        if (stop) begin
            state_d = ST_IDLE;
        end else begin
            state_d = state_d;
        end

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cuenta_q <= {WIDTH{1'b0}};
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cuenta_q <= cuenta_d;
            tc_q     <= tc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign cuenta = cuenta_q;
    assign tc     = tc_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
